// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer with four registers behind a single-slave req/ack handshake.
// Define TIMER_IRQ_EN to add the irq output and a stored CTRL.irq_en bit.
module mmio_timer #(
  parameter logic [31:0] BASE_ADRS = 32'hFFFF_0010
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adrs,
  input  logic [31:0] data,
  output logic [31:0] q,
  output logic        ack
`ifdef TIMER_IRQ_EN
  ,
  output logic        irq
`endif
);

  typedef enum logic [1:0] {StIdle, StResp, StDrop} state_e;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic        reload_q, reload_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        status_q, status_d;
  logic [31:0] q_q, q_d;

  logic        hit, accept, aligned, wr_en, rd_en, match, ctrl_irq_en;
  logic [31:0] rdata;

`ifdef TIMER_IRQ_EN
  logic irq_en_q, irq_en_d;
  assign ctrl_irq_en = irq_en_q;
  assign irq         = status_q & irq_en_q;
`else
  assign ctrl_irq_en = 1'b0;
`endif

  assign hit     = req & (adrs[31:4] == BASE_ADRS[31:4]);
  // Only a hit seen in IDLE is a new transaction; later cycles of the same request are ignored.
  assign accept  = (state_q == StIdle) & hit;
  assign aligned = (adrs[1:0] == 2'b00);
  assign wr_en   = accept & we & aligned;
  assign rd_en   = accept & ~we & aligned;
  assign match   = en_q & (count_q == compare_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hit) state_d = StResp;
      StResp:  state_d = StDrop;
      StDrop:  if (!req) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (adrs[3:2])
      2'd0: rdata = {29'd0, ctrl_irq_en, reload_q, en_q};
      2'd1: rdata = count_q;
      2'd2: rdata = compare_q;
      2'd3: rdata = {31'd0, status_q};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    q_d       = rd_en ? rdata : '0;
    en_d      = en_q;
    reload_d  = reload_q;
    compare_d = compare_q;
`ifdef TIMER_IRQ_EN
    irq_en_d  = irq_en_q;
`endif
    if (wr_en && adrs[3:2] == 2'd0) begin
      en_d     = data[0];
      reload_d = data[1];
`ifdef TIMER_IRQ_EN
      irq_en_d = data[2];
`endif
    end
    if (wr_en && adrs[3:2] == 2'd2) compare_d = data;

    // Priority: CPU write over reload over increment.
    count_d = count_q;
    if (en_q) count_d = (match && reload_q) ? 32'd0 : count_q + 32'd1;
    if (wr_en && adrs[3:2] == 2'd1) count_d = data;

    // A match set beats a same-cycle W1C.
    status_d = status_q;
    if (wr_en && adrs[3:2] == 2'd3 && data[0]) status_d = 1'b0;
    if (match) status_d = 1'b1;
  end

  always_ff @(posedge clk_cpu) begin
    if (!reset) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      reload_q  <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      status_q  <= 1'b0;
      q_q       <= 32'd0;
`ifdef TIMER_IRQ_EN
      irq_en_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      q_q       <= q_d;
`ifdef TIMER_IRQ_EN
      irq_en_q  <= irq_en_d;
`endif
    end
  end

  assign ack = (state_q == StResp);
  assign q   = q_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer; consecutive xfer calls capture 4 edges apart.
// Honours TIMER_IRQ_EN to exercise the irq output when the DUT is built with it.
module tb_mmio_timer;
  localparam logic [31:0] BASE = 32'hFFFF_0010;

  logic        clk_cpu = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adrs = '0;
  logic [31:0] data = '0;
  logic [31:0] q;
  logic        ack;
`ifdef TIMER_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  mmio_timer #(.BASE_ADRS(BASE)) dut (
    .clk_cpu(clk_cpu),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .adrs   (adrs),
    .data   (data),
    .q      (q),
`ifdef TIMER_IRQ_EN
    .irq    (irq),
`endif
    .ack    (ack)
  );

  always #5 clk_cpu = ~clk_cpu;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One bus transaction; lat = edges until ack (1 expected), -1 if none within 4.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat);
    rd  = '0;
    lat = -1;
    @(posedge clk_cpu); #1;
    req = 1'b1; we = w; adrs = a; data = d;
    for (int i = 1; i <= 4 && lat < 0; i++) begin
      @(posedge clk_cpu); #1;
      if (ack) begin
        lat = i;
        rd  = q;
      end
    end
    req = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk_cpu);
  endtask

  task automatic do_reset();
    @(posedge clk_cpu); #1;
    reset = 1'b0; req = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk_cpu);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int lat;
    do_reset();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", ack); end
    checks++; if (q !== 32'd0) begin errors++; $display("FAIL rst_q: got %h want 0", q); end
`ifdef TIMER_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
`endif
    xfer(1'b0, BASE + 32'h8, '0, v, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL rst_latency: got %0d want 1", lat); end
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_compare: got %h want ffffffff", v); end
    xfer(1'b0, BASE + 32'h0, '0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", v); end
    xfer(1'b0, BASE + 32'h4, '0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_count: got %h want 0", v); end
    xfer(1'b0, BASE + 32'hC, '0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_status: got %h want 0", v); end
  endtask

  // CTRL store captured at e0; COUNT after edge e0+k is k mod 6 while running.
  task automatic test_count_match();
    logic [31:0] v;
    int lat;
    do_reset();
    xfer(1'b1, BASE + 32'h8, 32'd5, v, lat);
    xfer(1'b1, BASE + 32'h0, 32'd3, v, lat);        // e0
    xfer(1'b0, BASE + 32'h4, '0, v, lat);           // e0+4
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL cm_count_a: got %0d want 3", v); end
    xfer(1'b0, BASE + 32'h4, '0, v, lat);           // e0+8
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL cm_count_reload: got %0d want 1", v); end
    xfer(1'b0, BASE + 32'hC, '0, v, lat);           // e0+12
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL cm_status_set: got %h want 1", v); end
    xfer(1'b1, BASE + 32'h0, 32'd0, v, lat);        // e0+16, COUNT freezes at 4
    xfer(1'b1, BASE + 32'hC, 32'd1, v, lat);        // e0+20
    xfer(1'b0, BASE + 32'hC, '0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL cm_status_w1c: got %h want 0", v); end
    xfer(1'b0, BASE + 32'h4, '0, v, lat);
    checks++; if (v !== 32'd4) begin errors++; $display("FAIL cm_count_frozen: got %0d want 4", v); end
  endtask

  task automatic test_set_wins();
    logic [31:0] v;
    int lat;
    do_reset();
    xfer(1'b1, BASE + 32'h8, 32'd5, v, lat);
    xfer(1'b1, BASE + 32'h0, 32'd3, v, lat);        // e0
    xfer(1'b0, BASE + 32'h4, '0, v, lat);
    xfer(1'b0, BASE + 32'h4, '0, v, lat);
    xfer(1'b1, BASE + 32'hC, 32'd1, v, lat);        // e0+12: COUNT==COMPARE here
    xfer(1'b1, BASE + 32'h0, 32'd0, v, lat);
    xfer(1'b0, BASE + 32'hC, '0, v, lat);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL set_wins_status: got %h want 1", v); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    int lat;
    do_reset();
    xfer(1'b1, BASE + 32'h8, 32'd0, v, lat);
    xfer(1'b1, BASE + 32'h4, 32'hFFFF_FFFE, v, lat);
    xfer(1'b1, BASE + 32'h0, 32'd1, v, lat);        // e0
    xfer(1'b0, BASE + 32'h4, '0, v, lat);           // FFFFFFFE, FFFFFFFF, 0, 1
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL wrap_count: got %h want 1", v); end
    xfer(1'b0, BASE + 32'hC, '0, v, lat);
    checks++; if (v !== 32'd1) begin errors++; $display("FAIL wrap_status: got %h want 1", v); end
    xfer(1'b0, BASE + 32'h4, '0, v, lat);
    checks++; if (v !== 32'd9) begin errors++; $display("FAIL wrap_continue: got %h want 9", v); end
  endtask

  task automatic test_bus();
    logic [31:0] v;
    int lat;
    int acks = 0;
    bit qbad = 1'b0;
    do_reset();
    @(posedge clk_cpu); #1;
    req = 1'b1; we = 1'b0; adrs = BASE + 32'h4;
    repeat (4) begin
      @(posedge clk_cpu); #1;
      if (ack) acks++;
      else if (q !== 32'd0) qbad = 1'b1;
    end
    req = 1'b0;
    repeat (2) @(posedge clk_cpu);
    checks++; if (acks !== 1) begin errors++; $display("FAIL bus_one_ack: got %0d want 1", acks); end
    checks++; if (qbad !== 1'b0) begin errors++; $display("FAIL bus_q_idle: got %b want 0", qbad); end
    xfer(1'b1, BASE + 32'h20, 32'd1, v, lat);
    checks++; if (lat !== -1) begin errors++; $display("FAIL bus_miss_ack: got %0d want -1", lat); end
    xfer(1'b0, BASE + 32'h0, '0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL bus_miss_ctrl: got %h want 0", v); end
    xfer(1'b1, BASE + 32'h5, 32'h1234, v, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL bus_misalign_ack: got %0d want 1", lat); end
    xfer(1'b0, BASE + 32'h4, '0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL bus_misalign_nowr: got %h want 0", v); end
    xfer(1'b0, BASE + 32'h9, '0, v, lat);
    checks++; if (lat !== 1 || v !== 32'd0) begin
      errors++; $display("FAIL bus_misalign_rd: got lat %0d q %h want lat 1 q 0", lat, v);
    end
  endtask

  task automatic test_write_wins_and_reset();
    logic [31:0] v;
    int lat;
    do_reset();
    xfer(1'b1, BASE + 32'h8, 32'd5, v, lat);
    xfer(1'b1, BASE + 32'h0, 32'd3, v, lat);        // e0
    xfer(1'b0, BASE + 32'h4, '0, v, lat);
    xfer(1'b0, BASE + 32'h4, '0, v, lat);
    xfer(1'b1, BASE + 32'h4, 32'd100, v, lat);      // e0+12: reload cycle
    xfer(1'b0, BASE + 32'h4, '0, v, lat);
    checks++; if (v !== 32'd103) begin errors++; $display("FAIL wr_wins_count: got %0d want 103", v); end
    @(posedge clk_cpu); #1;
    req = 1'b1; we = 1'b0; adrs = BASE + 32'h8;
    @(posedge clk_cpu); #1;
    checks++; if (ack !== 1'b1 || q !== 32'd5) begin
      errors++; $display("FAIL rresp_ack: got ack %b q %h want ack 1 q 5", ack, q);
    end
    reset = 1'b0;
    @(posedge clk_cpu); #1;
    @(posedge clk_cpu); #1;
    checks++; if (ack !== 1'b0 || q !== 32'd0) begin
      errors++; $display("FAIL rresp_drop: got ack %b q %h want ack 0 q 0", ack, q);
    end
    reset = 1'b1; req = 1'b0;
    repeat (2) @(posedge clk_cpu);
    xfer(1'b0, BASE + 32'h0, '0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rresp_ctrl: got %h want 0", v); end
    xfer(1'b0, BASE + 32'h4, '0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rresp_count: got %h want 0", v); end
    xfer(1'b0, BASE + 32'h8, '0, v, lat);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rresp_compare: got %h want ffffffff", v); end
    xfer(1'b0, BASE + 32'hC, '0, v, lat);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rresp_status: got %h want 0", v); end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    int lat;
    do_reset();
`ifdef TIMER_IRQ_EN
    xfer(1'b1, BASE + 32'h8, 32'd5, v, lat);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
    xfer(1'b1, BASE + 32'h0, 32'd7, v, lat);        // e0
    xfer(1'b0, BASE + 32'h0, '0, v, lat);           // returns at e0+6, match set there
    checks++; if (v !== 32'd7) begin errors++; $display("FAIL irq_ctrl_rd: got %h want 7", v); end
    #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq); end
    xfer(1'b1, BASE + 32'h0, 32'd4, v, lat);
    xfer(1'b1, BASE + 32'hC, 32'd1, v, lat);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", irq); end
`else
    xfer(1'b1, BASE + 32'h0, 32'd7, v, lat);
    xfer(1'b0, BASE + 32'h0, '0, v, lat);
    checks++; if (v !== 32'd3) begin errors++; $display("FAIL ctrl_no_irq: got %h want 3", v); end
`endif
  endtask

  initial begin
    test_reset();
    test_count_match();
    test_set_wins();
    test_wrap();
    test_bus();
    test_write_wins_and_reset();
    test_irq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
